// File: rtl/pampy_pkg.sv
// Shared constants for the pampy stack-machine control unit: opcodes, FSM
// state encodings, datapath mux encodings, error codes and the strobe bundle.
package pampy_pkg;

  // Opcodes (8-bit encodings; wider instruction words zero-extend them)
  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_LOAD_CONST = 8'h01;
  localparam logic [7:0] OP_ALU_BASE   = 8'h10;  // 0x10..0x1F, low nibble = ALU op
  localparam logic [7:0] OP_JUMP       = 8'h20;
  localparam logic [7:0] OP_PJIF       = 8'h21;
  localparam logic [7:0] OP_CALL       = 8'h30;
  localparam logic [7:0] OP_RET        = 8'h31;
  localparam logic [7:0] OP_HALT       = 8'hFF;

  // FSM state encodings
  localparam int STATE_W = 5;
  localparam logic [4:0] S_IDLE      = 5'd0;
  localparam logic [4:0] S_FETCH_OP  = 5'd1;
  localparam logic [4:0] S_FETCH_ARG = 5'd2;
  localparam logic [4:0] S_DECODE    = 5'd3;
  localparam logic [4:0] S_PUSH      = 5'd4;
  localparam logic [4:0] S_POP1      = 5'd5;
  localparam logic [4:0] S_POP2      = 5'd6;
  localparam logic [4:0] S_EXEC_ALU  = 5'd7;
  localparam logic [4:0] S_JMP       = 5'd8;
  localparam logic [4:0] S_CMP       = 5'd9;
  localparam logic [4:0] S_COND      = 5'd10;
  localparam logic [4:0] S_CALL_PUSH = 5'd11;
  localparam logic [4:0] S_RET_POP   = 5'd12;
  localparam logic [4:0] S_RET_FN    = 5'd13;
  localparam logic [4:0] S_RET_PC    = 5'd14;
  localparam logic [4:0] S_RET_PUSH  = 5'd15;
  localparam logic [4:0] S_HALT      = 5'd16;

  // PC source mux
  localparam logic [1:0] PC_SEL_INC = 2'd0;
  localparam logic [1:0] PC_SEL_ARG = 2'd1;
  localparam logic [1:0] PC_SEL_FN  = 2'd2;

  // Operand-stack write-data mux
  localparam logic [1:0] STK_SEL_ULA = 2'd0;
  localparam logic [1:0] STK_SEL_ARG = 2'd1;
  localparam logic [1:0] STK_SEL_RET = 2'd2;
  localparam logic [1:0] STK_SEL_MEM = 2'd3;

  // TOS and function-stack pointer direction
  localparam logic TOS_INC = 1'b0;
  localparam logic TOS_DEC = 1'b1;
  localparam logic FN_INC  = 1'b0;
  localparam logic FN_DEC  = 1'b1;

  // Error codes (sticky until reset)
  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

  // One cycle's worth of datapath controls
  typedef struct packed {
    logic       reg_instr;
    logic       reg_arg;
    logic       reg_pc;
    logic [1:0] mux_pc;
    logic       pc_updater;
    logic       reg_op1;
    logic       reg_op2;
    logic [3:0] ula;
    logic       stack_comp;
    logic       stack;
    logic       reg_tos;
    logic       mux_tos;
    logic [1:0] mux_stack;
    logic       stack_function;
    logic       reg_tos_function;
    logic       somador_subtrator;
    logic       reg_data_return;
  } ctrl_t;

  // States that push onto the operand stack
  function automatic logic is_push_state(logic [4:0] s);
    return (s == S_PUSH) || (s == S_EXEC_ALU) || (s == S_RET_PUSH);
  endfunction

  // States that pop from the operand stack
  function automatic logic is_pop_state(logic [4:0] s);
    return (s == S_POP1) || (s == S_POP2) || (s == S_CMP) || (s == S_RET_POP);
  endfunction

endpackage

// File: rtl/pampy_control_unit_depth.sv
// Operand-stack depth tracker: saturating up/down counter with empty/full flags.
module pampy_stack_depth #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inc_i,
  input  logic                  dec_i,
  output logic [ADDR_WIDTH-1:0] depth_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] depth_q, depth_d;

  // Next depth: move by one, never past either end
  always_comb begin
    depth_d = depth_q;
    if (inc_i && !dec_i && (depth_q != DEPTH_MAX)) begin
      depth_d = depth_q + DEPTH_ONE;
    end else if (dec_i && !inc_i && (depth_q != '0)) begin
      depth_d = depth_q - DEPTH_ONE;
    end
  end

  // Depth register, cleared by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  assign depth_o = depth_q;
  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == DEPTH_MAX);

endmodule

// File: rtl/pampy_control_unit.sv
// Control FSM for the pampy stack datapath. Fetches opcode and argument,
// decodes, and issues one set of datapath strobes per cycle. Outputs decode
// the registered state (and registered depth flags) only; the single
// exception is COND, where the compare result from the datapath decides
// whether the jump strobes fire in that same cycle.
module pampy_control_unit
  import pampy_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] reg_instr,
  input  logic                  stack_comp_out,
  input  logic                  reg_overflow_out,
  output logic                  ctrl_reg_instr,
  output logic                  ctrl_reg_arg,
  output logic                  ctrl_reg_pc,
  output logic [1:0]            sel_mux_pc,
  output logic                  sel_pc_updater,
  output logic                  ctrl_reg_op1,
  output logic                  ctrl_reg_op2,
  output logic [3:0]            sel_ula,
  output logic                  ctrl_stack_comp,
  output logic                  ctrl_stack,
  output logic                  ctrl_reg_tos,
  output logic                  sel_mux_tos,
  output logic [1:0]            sel_mux_stack,
  output logic                  ctrl_stack_function,
  output logic                  ctrl_reg_tos_function,
  output logic                  sel_somador_subtrator,
  output logic                  ctrl_reg_data_return,
  output logic                  halted,
  output logic [1:0]            error,
  output logic [STATE_W-1:0]    dbg_state,
  output logic [ADDR_WIDTH-1:0] dbg_depth
);

  localparam logic [DATA_WIDTH-5:0] ALU_TAG = (DATA_WIDTH-4)'(OP_ALU_BASE >> 4);

  logic [STATE_W-1:0] state_q, state_d;
  logic [1:0]         error_q, error_d;
  logic               depth_empty, depth_full;
  logic               push_ok, pop_ok;
  logic               is_alu;
  ctrl_t              ctrl;

  assign is_alu = (reg_instr[DATA_WIDTH-1:4] == ALU_TAG);

  // A push/pop state only takes effect when the stack has room/contents;
  // otherwise its strobes are withheld and the FSM aborts to HALT.
  assign push_ok = is_push_state(state_q) && !depth_full;
  assign pop_ok  = is_pop_state(state_q) && !depth_empty;

  pampy_stack_depth #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_depth (
    .clk_i  (clk),
    .rst_i  (reset),
    .inc_i  (push_ok),
    .dec_i  (pop_ok),
    .depth_o(dbg_depth),
    .empty_o(depth_empty),
    .full_o (depth_full)
  );

  // Next-state and error logic
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    case (state_q)
      S_IDLE:      state_d = S_FETCH_OP;
      S_FETCH_OP:  state_d = S_FETCH_ARG;
      S_FETCH_ARG: state_d = S_DECODE;
      S_DECODE: begin
        if (reg_instr == DATA_WIDTH'(OP_NOP)) begin
          state_d = S_FETCH_OP;
        end else if (reg_instr == DATA_WIDTH'(OP_LOAD_CONST)) begin
          state_d = S_PUSH;
        end else if (is_alu) begin
          state_d = S_POP1;
        end else if (reg_instr == DATA_WIDTH'(OP_JUMP)) begin
          state_d = S_JMP;
        end else if (reg_instr == DATA_WIDTH'(OP_PJIF)) begin
          state_d = S_CMP;
        end else if (reg_instr == DATA_WIDTH'(OP_CALL)) begin
          state_d = S_CALL_PUSH;
        end else if (reg_instr == DATA_WIDTH'(OP_RET)) begin
          state_d = S_RET_POP;
        end else if (reg_instr == DATA_WIDTH'(OP_HALT)) begin
          state_d = S_HALT;
          error_d = ERR_NONE;
        end else begin
          state_d = S_HALT;
          error_d = ERR_ILLEGAL;
        end
      end
      S_PUSH, S_RET_PUSH: begin
        if (depth_full) begin
          state_d = S_HALT;
          error_d = ERR_OVERFLOW;
        end else begin
          state_d = S_FETCH_OP;
        end
      end
      S_POP1, S_POP2, S_CMP, S_RET_POP: begin
        if (depth_empty) begin
          state_d = S_HALT;
          error_d = ERR_UNDERFLOW;
        end else begin
          case (state_q)
            S_POP1:  state_d = S_POP2;
            S_POP2:  state_d = S_EXEC_ALU;
            S_CMP:   state_d = S_COND;
            default: state_d = S_RET_FN;
          endcase
        end
      end
      S_EXEC_ALU: begin
        // An ALU overflow still lets the result be pushed, then stops.
        if (depth_full || reg_overflow_out) begin
          state_d = S_HALT;
          error_d = ERR_OVERFLOW;
        end else begin
          state_d = S_FETCH_OP;
        end
      end
      S_JMP:       state_d = S_FETCH_OP;
      S_COND:      state_d = S_FETCH_OP;
      S_CALL_PUSH: state_d = S_JMP;
      S_RET_FN:    state_d = S_RET_PC;
      S_RET_PC:    state_d = S_RET_PUSH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // State and sticky error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      error_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  // Per-state strobe decode
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH_OP: begin
        ctrl.reg_instr  = 1'b1;
        ctrl.reg_pc     = 1'b1;
        ctrl.mux_pc     = PC_SEL_INC;
        ctrl.pc_updater = 1'b1;
      end
      S_FETCH_ARG: begin
        ctrl.reg_arg = 1'b1;
        ctrl.reg_pc  = 1'b1;
        ctrl.mux_pc  = PC_SEL_INC;
      end
      S_PUSH: begin
        if (push_ok) begin
          ctrl.stack     = 1'b1;
          ctrl.reg_tos   = 1'b1;
          ctrl.mux_tos   = TOS_INC;
          ctrl.mux_stack = STK_SEL_ARG;
        end
      end
      S_POP1: begin
        if (pop_ok) begin
          ctrl.reg_op1 = 1'b1;
          ctrl.reg_tos = 1'b1;
          ctrl.mux_tos = TOS_DEC;
        end
      end
      S_POP2: begin
        if (pop_ok) begin
          ctrl.reg_op2 = 1'b1;
          ctrl.reg_tos = 1'b1;
          ctrl.mux_tos = TOS_DEC;
        end
      end
      S_EXEC_ALU: begin
        ctrl.ula = reg_instr[3:0];
        if (push_ok) begin
          ctrl.stack     = 1'b1;
          ctrl.reg_tos   = 1'b1;
          ctrl.mux_tos   = TOS_INC;
          ctrl.mux_stack = STK_SEL_ULA;
        end
      end
      S_JMP: begin
        ctrl.reg_pc = 1'b1;
        ctrl.mux_pc = PC_SEL_ARG;
      end
      S_CMP: begin
        if (pop_ok) begin
          ctrl.stack_comp = 1'b1;
          ctrl.reg_tos    = 1'b1;
          ctrl.mux_tos    = TOS_DEC;
        end
      end
      S_COND: begin
        // Compare result is valid only now, one cycle after the latch strobe.
        if (!stack_comp_out) begin
          ctrl.reg_pc = 1'b1;
          ctrl.mux_pc = PC_SEL_ARG;
        end
      end
      S_CALL_PUSH: begin
        ctrl.stack_function    = 1'b1;
        ctrl.reg_tos_function  = 1'b1;
        ctrl.somador_subtrator = FN_INC;
      end
      S_RET_POP: begin
        if (pop_ok) begin
          ctrl.reg_data_return = 1'b1;
          ctrl.reg_tos         = 1'b1;
          ctrl.mux_tos         = TOS_DEC;
        end
      end
      S_RET_FN: begin
        ctrl.reg_tos_function  = 1'b1;
        ctrl.somador_subtrator = FN_DEC;
      end
      S_RET_PC: begin
        ctrl.reg_pc = 1'b1;
        ctrl.mux_pc = PC_SEL_FN;
      end
      S_RET_PUSH: begin
        if (push_ok) begin
          ctrl.stack     = 1'b1;
          ctrl.reg_tos   = 1'b1;
          ctrl.mux_tos   = TOS_INC;
          ctrl.mux_stack = STK_SEL_RET;
        end
      end
      default: ctrl = '0;
    endcase
  end

  assign ctrl_reg_instr        = ctrl.reg_instr;
  assign ctrl_reg_arg          = ctrl.reg_arg;
  assign ctrl_reg_pc           = ctrl.reg_pc;
  assign sel_mux_pc            = ctrl.mux_pc;
  assign sel_pc_updater        = ctrl.pc_updater;
  assign ctrl_reg_op1          = ctrl.reg_op1;
  assign ctrl_reg_op2          = ctrl.reg_op2;
  assign sel_ula               = ctrl.ula;
  assign ctrl_stack_comp       = ctrl.stack_comp;
  assign ctrl_stack            = ctrl.stack;
  assign ctrl_reg_tos          = ctrl.reg_tos;
  assign sel_mux_tos           = ctrl.mux_tos;
  assign sel_mux_stack         = ctrl.mux_stack;
  assign ctrl_stack_function   = ctrl.stack_function;
  assign ctrl_reg_tos_function = ctrl.reg_tos_function;
  assign sel_somador_subtrator = ctrl.somador_subtrator;
  assign ctrl_reg_data_return  = ctrl.reg_data_return;
  assign halted                = (state_q == S_HALT);
  assign error                 = error_q;
  assign dbg_state             = state_q;

endmodule
